// File: rtl/frame_pixel_streamer.sv
// Reads a finished frame out of the Color/Weight SRAM and streams it one RGB pixel per cycle.
// A two-entry word FIFO with read prefetch keeps the stream gapless while pix_ready stays high.
module frame_pixel_streamer #(
   parameter int unsigned FRAME_WORDS = 4096,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned PIX_IDX_W   = 20
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   output logic                 sram_rd_en,
   output logic [ADDR_W-1:0]    sram_addr,
   input  logic [383:0]         sram_rdata,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [23:0]          pix_data,
   output logic [PIX_IDX_W-1:0] pix_index,
   output logic                 pix_last,
   output logic                 busy,
   output logic                 done
);
   localparam int unsigned          CNT_W    = $clog2(FRAME_WORDS + 1);
   localparam logic [CNT_W-1:0]     WORDS    = CNT_W'(FRAME_WORDS);
   localparam logic [PIX_IDX_W-1:0] LAST_IDX = PIX_IDX_W'(16 * FRAME_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      base_q, base_d;
   logic [CNT_W-1:0]       issued_q, issued_d;
   logic                   rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   inflight_q, inflight_d;
   logic [383:0]           word_buf_q [2];
   logic [383:0]           word_buf_d [2];
   logic                   wr_ptr_q, wr_ptr_d;
   logic                   rd_ptr_q, rd_ptr_d;
   logic [1:0]             count_q, count_d;
   logic [3:0]             lane_q, lane_d;
   logic                   valid_q, valid_d;
   logic [23:0]            data_q, data_d;
   logic [PIX_IDX_W-1:0]   index_q, index_d;
   logic                   last_q, last_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   fill, drain, xfer;
   logic [15:0][23:0]      lanes;

   always_comb begin
      // NOTE: every _d signal gets a default first so no path through this block infers a latch.
      state_d    = state_q;
      base_d     = base_q;
      issued_d   = issued_q;
      rd_en_d    = 1'b0;
      addr_d     = addr_q;
      inflight_d = rd_en_q;
      word_buf_d = word_buf_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      lane_d     = lane_q;
      index_d    = index_q;
      fill       = 1'b0;
      drain      = 1'b0;
      xfer       = valid_q && pix_ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               base_d   = base_addr;
               issued_d = '0;
               wr_ptr_d = 1'b0;
               rd_ptr_d = 1'b0;
               lane_d   = '0;
               index_d  = '0;
            end
         end
         S_RUN: begin
            if (inflight_q) begin
               word_buf_d[wr_ptr_q] = sram_rdata;
               wr_ptr_d             = ~wr_ptr_q;
               fill                 = 1'b1;
            end
            if (xfer) begin
               index_d = index_q + 1'b1;
               lane_d  = lane_q + 1'b1;
               if (lane_q == 4'd15) begin
                  rd_ptr_d = ~rd_ptr_q;
                  drain    = 1'b1;
               end
               if (last_q) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      count_d = count_q + {1'b0, fill} - {1'b0, drain};

      // Buffered words plus the read launched last cycle must leave room for one more word.
      if (state_q == S_RUN && issued_q < WORDS && (count_d + {1'b0, rd_en_q}) < 2'd2) begin
         rd_en_d  = 1'b1;
         addr_d   = base_q + ADDR_W'(issued_q);
         issued_d = issued_q + 1'b1;
      end

      lanes   = word_buf_d[rd_ptr_d];
      valid_d = (state_d == S_RUN) && (count_d != 2'd0);
      data_d  = valid_d ? lanes[lane_d] : '0;
      if (state_d != S_RUN) index_d = '0;
      last_d  = valid_d && (index_d == LAST_IDX);
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         issued_q   <= '0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
         lane_q     <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         index_q    <= '0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         issued_q   <= issued_d;
         rd_en_q    <= rd_en_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         lane_q     <= lane_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         index_q    <= index_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // NOTE: word storage has no reset; count_q alone marks entries valid, so stale words are never read.
   always_ff @(posedge clk) word_buf_q <= word_buf_d;

   assign sram_rd_en = rd_en_q;
   assign sram_addr  = addr_q;
   assign pix_valid  = valid_q;
   assign pix_data   = data_q;
   assign pix_index  = index_q;
   assign pix_last   = last_q;
   assign busy       = busy_q;
   assign done       = done_q;
endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Self-checking bench: a 2-word-frame instance driven by a scenario table plus random frames,
// and a 1-word-frame instance driven by a hand-written stall sequence.
module tb_frame_pixel_streamer;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic srst;

   logic         a_start, a_rd_en, a_valid, a_ready, a_last, a_busy, a_done;
   logic [15:0]  a_base, a_addr;
   logic [383:0] a_rdata;
   logic [23:0]  a_data;
   logic [19:0]  a_index;

   logic         b_start, b_rd_en, b_valid, b_ready, b_last, b_busy, b_done;
   logic [15:0]  b_base, b_addr;
   logic [383:0] b_rdata;
   logic [23:0]  b_data;
   logic [19:0]  b_index;

   frame_pixel_streamer #(.FRAME_WORDS(2), .ADDR_W(16), .PIX_IDX_W(20)) dut_a (
      .clk(clk), .srst(srst), .start(a_start), .base_addr(a_base),
      .sram_rd_en(a_rd_en), .sram_addr(a_addr), .sram_rdata(a_rdata),
      .pix_valid(a_valid), .pix_ready(a_ready), .pix_data(a_data), .pix_index(a_index),
      .pix_last(a_last), .busy(a_busy), .done(a_done));

   frame_pixel_streamer #(.FRAME_WORDS(1), .ADDR_W(16), .PIX_IDX_W(20)) dut_b (
      .clk(clk), .srst(srst), .start(b_start), .base_addr(b_base),
      .sram_rd_en(b_rd_en), .sram_addr(b_addr), .sram_rdata(b_rdata),
      .pix_valid(b_valid), .pix_ready(b_ready), .pix_data(b_data), .pix_index(b_index),
      .pix_last(b_last), .busy(b_busy), .done(b_done));

   int n_tests = 0;
   int n_fail  = 0;

   // SRAM content: lane j of the word k places after mem_origin is {k, j, salt}.
   logic [7:0]  salt;
   logic [15:0] mem_origin;

   function automatic logic [23:0] lane_of(input logic [15:0] addr, input int j);
      logic [15:0] k;
      k = addr - mem_origin;
      return {k[7:0], 8'(j), salt};
   endfunction

   function automatic logic [383:0] word_of(input logic [15:0] addr);
      logic [383:0] w;
      for (int j = 0; j < 16; j++) w[24*j +: 24] = lane_of(addr, j);
      return w;
   endfunction

   // Pixel i of a frame is lane i%16 of the word at base + i/16 (16-bit wrap).
   function automatic logic [23:0] exp_pixel(input logic [15:0] base, input int i);
      return lane_of(base + 16'(i / 16), i % 16);
   endfunction

   // Read data is valid one cycle after the strobe; junk otherwise exposes mistimed captures.
   always @(posedge clk) begin
      a_rdata <= a_rd_en ? word_of(a_addr) : {12{$urandom}};
      b_rdata <= b_rd_en ? word_of(b_addr) : {12{$urandom}};
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] base;
      int          mode;        // 0: ready=1, 1: ready 1,0,0,1 repeating, 2: random ready
      int          repulse_at;  // pixel count at which start is pulsed again, -1 = never
      int          rst_at;      // pixel count at which srst is pulsed, -1 = never
      int          exp_reads;
      logic [15:0] exp_addr0;
      logic [15:0] exp_addr1;
      int          exp_pixels;
      int          exp_dones;
   } vec_t;

   task automatic run_frame(input vec_t v, output int reads, output logic [15:0] ad0,
                            output logic [15:0] ad1, output int pixels, output int dones,
                            output int first, output int first_rd, output int last_c);
      int          stop_at, rst_c;
      bit          repulsed, rst_fired, prev_stall;
      logic [23:0] pd;
      logic [19:0] pi;
      logic        pl;
      logic [3:0]  pat;
      pat = 4'b1001;
      reads = 0; ad0 = '0; ad1 = '0; pixels = 0; dones = 0;
      first = -1; first_rd = -1; last_c = -100; stop_at = -1; rst_c = -100;
      repulsed = 0; rst_fired = 0; prev_stall = 0;
      pd = '0; pi = '0; pl = 1'b0;
      mem_origin = v.base;
      @(posedge clk); #1;
      srst = 1'b0; a_start = 1'b1; a_base = v.base; a_ready = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         a_start = 1'b0;
         srst    = 1'b0;
         if (v.repulse_at >= 0 && pixels == v.repulse_at && !repulsed) begin
            a_start = 1'b1; a_base = v.base ^ 16'h0700; repulsed = 1;
         end
         if (v.rst_at >= 0 && pixels == v.rst_at && !rst_fired) begin
            srst = 1'b1; rst_fired = 1; rst_c = c; stop_at = c + 15;
         end
         case (v.mode)
            0:       a_ready = 1'b1;
            1:       a_ready = pat[c % 4];
            default: a_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (c == rst_c + 1)
            check("reset_outputs_zero",
                  {a_rd_en, a_addr, a_valid, a_data, a_index, a_last, a_busy, a_done}, '0);
         if (a_rd_en) begin
            if (reads == 0) begin ad0 = a_addr; first_rd = c; end
            else if (reads == 1) ad1 = a_addr;
            reads++;
         end
         if (a_valid && first < 0) first = c;
         if (prev_stall) begin
            check("stall_valid_held", a_valid, 1'b1);
            check("stall_data_held", {a_data, a_index, a_last}, {pd, pi, pl});
         end
         prev_stall = a_valid && !a_ready && !srst;
         pd = a_data; pi = a_index; pl = a_last;
         if (a_valid && a_ready && !srst) begin
            check($sformatf("pix%0d_data", pixels), a_data, exp_pixel(v.base, pixels));
            check($sformatf("pix%0d_index", pixels), a_index, 20'(pixels));
            check($sformatf("pix%0d_last", pixels), a_last, pixels == 31);
            pixels++;
            last_c = c;
         end
         if (a_done) begin
            dones++;
            check("done_one_after_last", c, last_c + 1);
            check("done_valid_low_busy_low", {a_valid, a_busy}, 2'b00);
            stop_at = c + 2;
         end
         if (stop_at >= 0 && c >= stop_at) break;
      end
      check("frame_ended_in_budget", stop_at >= 0, 1'b1);
   endtask

   localparam int NV = 6;
   vec_t        vt [NV];
   vec_t        rv;
   int          reads, pixels, dones, first, first_rd, last_c, held, end_at;
   logic [15:0] ad0, ad1;

   initial begin
      srst = 1'b1;
      a_start = 1'b0; a_base = '0; a_ready = 1'b1;
      b_start = 1'b0; b_base = '0; b_ready = 1'b0;
      salt = 8'hA5; mem_origin = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("a_reset_state", {a_rd_en, a_addr, a_valid, a_data, a_index, a_last, a_busy, a_done}, '0);
      check("b_reset_state", {b_rd_en, b_addr, b_valid, b_data, b_index, b_last, b_busy, b_done}, '0);
      srst = 1'b0;

      //          base      mode repulse rst  reads addr0     addr1     pix dones
      vt[0] = '{16'h0010, 0,   -1,     -1,  2,    16'h0010, 16'h0011, 32, 1};
      vt[1] = '{16'h0010, 1,   -1,     -1,  2,    16'h0010, 16'h0011, 32, 1};
      vt[2] = '{16'hFFFF, 0,   -1,     -1,  2,    16'hFFFF, 16'h0000, 32, 1};
      vt[3] = '{16'h0010, 0,    5,     -1,  2,    16'h0010, 16'h0011, 32, 1};
      vt[4] = '{16'h0040, 0,   -1,     20,  2,    16'h0040, 16'h0041, 20, 0};
      vt[5] = '{16'h0040, 0,   -1,     -1,  2,    16'h0040, 16'h0041, 32, 1};

      for (int r = 0; r < NV; r++) begin
         run_frame(vt[r], reads, ad0, ad1, pixels, dones, first, first_rd, last_c);
         check($sformatf("row%0d_reads", r), reads, vt[r].exp_reads);
         check($sformatf("row%0d_addr0", r), ad0, vt[r].exp_addr0);
         check($sformatf("row%0d_addr1", r), ad1, vt[r].exp_addr1);
         check($sformatf("row%0d_pixels", r), pixels, vt[r].exp_pixels);
         check($sformatf("row%0d_dones", r), dones, vt[r].exp_dones);
         check($sformatf("row%0d_first_read_cycle", r), first_rd, 2);
         check($sformatf("row%0d_first_valid_cycle", r), first, 4);
         if (vt[r].mode == 0 && vt[r].exp_dones == 1)
            check($sformatf("row%0d_no_gaps", r), last_c - first, 31);
      end

      for (int r = 0; r < 6; r++) begin
         rv = '{16'($urandom), 2, -1, -1, 2, 16'h0, 16'h0, 32, 1};
         rv.exp_addr0 = rv.base;
         rv.exp_addr1 = rv.base + 16'd1;
         salt = 8'($urandom);
         run_frame(rv, reads, ad0, ad1, pixels, dones, first, first_rd, last_c);
         check($sformatf("rand%0d_reads", r), reads, rv.exp_reads);
         check($sformatf("rand%0d_addrs", r), {ad0, ad1}, {rv.exp_addr0, rv.exp_addr1});
         check($sformatf("rand%0d_pixels", r), pixels, rv.exp_pixels);
         check($sformatf("rand%0d_dones", r), dones, rv.exp_dones);
      end

      // One-word frame: pixel 0 held for 10 cycles of ready=0, then 16 transfers.
      mem_origin = 16'h0200; salt = 8'h3C;
      reads = 0; pixels = 0; dones = 0; held = 0; last_c = -100; end_at = -1;
      @(posedge clk); #1;
      b_start = 1'b1; b_base = 16'h0200; b_ready = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         b_start = 1'b0;
         b_ready = (held >= 10);
         @(negedge clk);
         if (b_rd_en) begin
            reads++;
            check("fw1_addr", b_addr, 16'h0200);
         end
         if (b_valid && !b_ready) begin
            held++;
            check("fw1_hold_data", {b_data, b_index}, {exp_pixel(16'h0200, 0), 20'd0});
         end
         if (b_valid && b_ready) begin
            check($sformatf("fw1_pix%0d_data", pixels), b_data, exp_pixel(16'h0200, pixels));
            check($sformatf("fw1_pix%0d_index", pixels), b_index, 20'(pixels));
            check($sformatf("fw1_pix%0d_last", pixels), b_last, pixels == 15);
            pixels++;
            last_c = c;
         end
         if (b_done) begin
            dones++;
            check("fw1_done_one_after_last", c, last_c + 1);
            end_at = c + 2;
         end
         if (end_at >= 0 && c >= end_at) break;
      end
      check("fw1_reads", reads, 1);
      check("fw1_hold_cycles", held, 10);
      check("fw1_pixels", pixels, 16);
      check("fw1_dones", dones, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
